// File: rtl/ysyx_24080014_inst_enc_pkg.sv
// Shared definitions for the instruction encoder and its users.
//   - imm_type_e      : immediate-format codes (R, I, S, U, B, J, ERROR)
//   - imm_range_err() : 1 when an immediate cannot be encoded in a format
//   - imm_decode()    : immediate decoder (inverse of the packer), so that
//                       encoder and decoder agree on one definition
package ysyx_24080014_inst_enc_pkg;

    typedef enum logic [2:0] {
        ImmR   = 3'b000,
        ImmI   = 3'b001,
        ImmS   = 3'b010,
        ImmU   = 3'b011,
        ImmB   = 3'b100,
        ImmJ   = 3'b101,
        ImmErr = 3'b110
    } imm_type_e;

    // A field is representable when all bits above its sign bit equal the
    // sign bit, i.e. the slice is all-zeros or all-ones.
    function automatic logic imm_range_err(input logic [2:0] imm_type, input logic [31:0] imm);
        logic err;
        unique case (imm_type)
            ImmR:       err = 1'b0;
            ImmI, ImmS: err = !((&imm[31:11]) || !(|imm[31:11]));
            ImmB:       err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            ImmJ:       err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            ImmU:       err = |imm[11:0];
            default:    err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] imm_decode(input logic [2:0] imm_type,
                                               input logic [31:0] inst);
        logic [31:0] imm;
        unique case (imm_type)
            ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
            ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ImmB:    imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            ImmU:    imm = {inst[31:12], 12'b0};
            ImmJ:    imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ysyx_24080014_imm_pack.sv
// Combinational instruction packer.
// Inputs : imm_type, imm, opcode, rd, rs1, rs2, funct3, funct7
// Outputs: inst (assembled RV32 word, 0 when err), err (imm not representable
//          in imm_type, or imm_type is not a valid format)
module ysyx_24080014_imm_pack
    import ysyx_24080014_inst_enc_pkg::*;
(
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] inst,
    output logic        err
);

    logic [31:0] packed_inst;

    always_comb begin
        packed_inst = 32'h0;
        unique case (imm_type)
            ImmR: packed_inst = {funct7, rs2, rs1, funct3, rd, opcode};
            ImmI: packed_inst = {imm[11:0], rs1, funct3, rd, opcode};
            ImmS: packed_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            ImmB: packed_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            ImmU: packed_inst = {imm[31:12], rd, opcode};
            ImmJ: packed_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: packed_inst = 32'h0;
        endcase
    end

    always_comb begin
        err  = imm_range_err(imm_type, imm);
        // All-zero word is the canonical illegal instruction.
        inst = err ? 32'h0 : packed_inst;
    end

endmodule

// File: rtl/ysyx_24080014_inst_enc.sv
// Two-stage valid/ready instruction encoder.
// Inputs : clk, rst (sync, active-high), in_valid, imm_type, imm, opcode, rd,
//          rs1, rs2, funct3, funct7, out_ready
// Outputs: in_ready, out_valid, out_inst, out_err,
//          err_cnt (saturating count of accepted erroneous requests)
// S1 holds the request plus its range-check result; S2 holds the packed word.
module ysyx_24080014_inst_enc
    import ysyx_24080014_inst_enc_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           imm_type,
    input  logic [31:0]          imm,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic        s1_valid_q;
    logic [2:0]  s1_type_q;
    logic [31:0] s1_imm_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic        s1_err_q;

    logic        s2_valid_q;
    logic [31:0] s2_inst_q;
    logic        s2_err_q;

    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic        adv1;
    logic        adv2;
    logic        in_err;
    logic        in_fire;
    logic [31:0] pack_inst;
    logic        pack_err;

    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
        in_fire  = in_valid && adv1;
        in_err   = imm_range_err(imm_type, imm);
    end

    // Stage 1: valid bit, and payload loaded only on an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_type_q   <= imm_type;
            s1_imm_q    <= imm;
            s1_opcode_q <= opcode;
            s1_rd_q     <= rd;
            s1_rs1_q    <= rs1;
            s1_rs2_q    <= rs2;
            s1_funct3_q <= funct3;
            s1_funct7_q <= funct7;
            s1_err_q    <= in_err;
        end
    end

    ysyx_24080014_imm_pack u_imm_pack (
        .imm_type (s1_type_q),
        .imm      (s1_imm_q),
        .opcode   (s1_opcode_q),
        .rd       (s1_rd_q),
        .rs1      (s1_rs1_q),
        .rs2      (s1_rs2_q),
        .funct3   (s1_funct3_q),
        .funct7   (s1_funct7_q),
        .inst     (pack_inst),
        .err      (pack_err)
    );

    // Stage 2: payload only moves when S1 has something to hand over, so the
    // output stays stable while stalled or drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_inst_q  <= 32'h0;
            s2_err_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_q <= (s1_err_q || pack_err) ? 32'h0 : pack_inst;
                s2_err_q  <= s1_err_q || pack_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (in_fire && in_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ysyx_24080014_inst_enc.sv
// Scoreboard bench: the driver pushes the expected {inst, err} when a request
// is accepted; the monitor pops and compares on every output transfer.
module tb_ysyx_24080014_inst_enc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_type = 3'b000;
    logic [31:0] imm = 32'h0;
    logic [6:0]  opcode = 7'h0;
    logic [4:0]  rd = 5'h0;
    logic [4:0]  rs1 = 5'h0;
    logic [4:0]  rs2 = 5'h0;
    logic [2:0]  funct3 = 3'h0;
    logic [6:0]  funct7 = 7'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_inst;
    logic        sat_out_err;
    logic [1:0]  sat_err_cnt;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    ysyx_24080014_inst_enc #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_type  (imm_type),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    // Same stimulus, narrow counter for the saturation scenario.
    ysyx_24080014_inst_enc #(.ERR_CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .imm_type  (imm_type),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_inst  (sat_out_inst),
        .out_err   (sat_out_err),
        .err_cnt   (sat_err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs only change #1 after a rising edge, so a transfer seen at
    // the falling edge is the one that happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {31'h0, out_err, out_inst}, 64'h0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("out_inst", {32'h0, out_inst}, {32'h0, e[31:0]});
                check("out_err", {63'h0, out_err}, {63'h0, e[32]});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [31:0] im, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] e_inst, input logic e_err);
        int n;
        imm_type = t; imm = im; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            check("accept_timeout", 64'h0, 64'h1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({e_err, e_inst});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            accepted++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_inst", {32'h0, out_inst}, 64'h0);
        check("rst_out_err", {63'h0, out_err}, 64'h0);
        check("rst_err_cnt", {56'h0, err_cnt}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        // I-type, with 2-cycle latency check
        send(3'b001, 32'hFFFF_FFFF, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0093, 1'b0);
        check("lat_after_accept", {63'h0, out_valid}, 64'h0);
        @(posedge clk);
        #1;
        check("lat_two_cycles", {63'h0, out_valid}, 64'h1);
        drain();

        // B-type, legal then misaligned
        send(3'b100, 32'hFFFF_FFFC, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFE00_0EE3, 1'b0);
        send(3'b100, 32'h0000_0003, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
        check("b_err_cnt", {56'h0, err_cnt}, 64'h1);
        drain();

        // Back-to-back J then U, then out-of-range I
        do_reset();
        send(3'b101, 32'h0000_0008, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0080_00EF, 1'b0);
        send(3'b011, 32'h1234_5000, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_52B7, 1'b0);
        send(3'b001, 32'h0000_0800, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
        check("i2048_err_cnt", {56'h0, err_cnt}, 64'h1);
        // R, S, and boundary cases
        send(3'b000, 32'hDEAD_BEEF, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0020_81B3, 1'b0);
        send(3'b010, 32'hFFFF_FFF8, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFE31_2C23, 1'b0);
        send(3'b001, 32'hFFFF_F800, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8000_0013, 1'b0);
        send(3'b011, 32'h0000_1001, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
        send(3'b101, 32'h0000_0005, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
        send(3'b111, 32'h0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
        check("mixed_err_cnt", {56'h0, err_cnt}, 64'h4);
        drain();

        // Backpressure: 3 requests offered, only 2 fit while stalled
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(3'b000, 32'h0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0020_81B3, 1'b0);
                send(3'b010, 32'hFFFF_FFF8, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0,
                     32'hFE31_2C23, 1'b0);
                send(3'b001, 32'h0000_0005, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h0050_0113, 1'b0);
            end
        join_none
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            if (i >= 2) begin
                check("stall_valid", {63'h0, out_valid}, 64'h1);
                check("stall_inst", {32'h0, out_inst}, 64'h0020_81B3);
            end
        end
        check("stall_in_ready", {63'h0, in_ready}, 64'h0);
        check("stall_accepted", 64'(accepted), 64'h2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_accepted", 64'(accepted), 64'h3);

        // Reset with both stages full; nothing may emerge afterwards
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(3'b110, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
        send(3'b001, 32'h0000_0001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0093, 1'b0);
        check("pre_rst_in_ready", {63'h0, in_ready}, 64'h0);
        do_reset();
        check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        check("midrst_err_cnt", {56'h0, err_cnt}, 64'h0);
        check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_stale", {63'h0, out_valid}, 64'h0);

        // Saturation on the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_sat;
            exp_sat = (i < 3) ? 2'(i + 1) : 2'd3;
            send(3'b110, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
            check("sat_err_cnt", {62'h0, sat_err_cnt}, {62'h0, exp_sat});
            check("wide_err_cnt", {56'h0, err_cnt}, 64'(i + 1));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
